sipo_rx: RTL and testbench
==========================

# sipo_rx

Serial-in/parallel-out receiver for the two-wire link (serial data plus forwarded serial clock) that the board's serializer drives. It oversamples the serial clock in the local clock domain, shifts data in MSB first on each serial-clock rising edge, and presents each completed word with a valid/ack handshake. The block also flags overruns and truncated frames. It sits at the receiving end of the link, between the line pins and the downstream register/FIFO logic.

## Interface
- WIDTH, 32, bits per word; also the number of serial-clock rising edges per frame.
- SYNC_STAGES, 2, flip-flop depth of the input synchronizers on sclk_in and sdata_in (≥2).
- IDLE_TIMEOUT, 16, clk cycles without a serial-clock rising edge, mid-frame, before the partial frame is aborted (≥4).
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- enable  input  1  1 = receive; 0 = discard any partial frame, hold the FSM in DISABLED.
- sclk_in  input  1  forwarded serial clock; idles low.
- sdata_in  input  1  serial data; stable around each sclk_in rising edge, changes while sclk_in falls.
- ack  input  1  consumer accepts data_out when valid=1.
- clr  input  1  clears the overrun flag.
- data_out  output  WIDTH  last accepted word; first received bit is in bit WIDTH-1.
- valid  output  1  data_out holds an unconsumed word.
- overrun  output  1  sticky: a completed word was dropped.
- frame_err  output  1  one-cycle pulse: a partial frame was aborted by timeout.
- bit_count  output  6  bits received in the current frame (debug).
- word_count  output  16  completed words, including dropped ones; wraps modulo 2^16.

## Operation
- Synchronize sclk_in and sdata_in through identical SYNC_STAGES chains. Then sclk_s is the synchronized clock and sclk_q is sclk_s delayed one cycle.
- rise = sclk_s & ~sclk_q. Sample sdata at the same pipeline depth as sclk_s so that data and clock stay aligned.
- On each rise in WAIT or SHIFT: shift_reg <= {shift_reg[WIDTH-2:0], sdata_s}, bit_count++, and reset the idle counter.
- FSM states:
  - DISABLED: entered from reset or whenever enable=0, from any state. bit_count=0. Go to WAIT when enable=1.
  - WAIT: no frame in progress, bit_count=0. The first rise loads bit 1 and moves the FSM to SHIFT.
  - SHIFT: the idle counter increments each cycle without a rise.
    - A rise that makes bit_count reach WIDTH completes the word. The FSM returns to WAIT with bit_count=0.
    - If the idle counter reaches IDLE_TIMEOUT: pulse frame_err, discard shift_reg, go to WAIT.
- enable falling mid-frame discards the frame silently, with no frame_err.
- On word completion:
  - If valid=0, or valid=1 and ack=1 in the same cycle: data_out <= completed word, valid=1.
  - If valid=1 and ack=0: the word is dropped, data_out is unchanged, and overrun is set.
  - word_count increments in every completion case.
- Handshake: valid stays high until ack is sampled high. When ack=1 and no completion occurs that cycle, valid drops next cycle. ack while valid=0 is ignored.
- overrun clears on clr=1. If clr and a new overrun occur in the same cycle, set wins.
- sclk_in must hold each level for at least 1 clk cycle when source-synchronous to clk, and for at least 2 clk cycles when asynchronous. A faster sclk_in is out of spec and may lose bits.

## Timing
- Reset values: data_out=0, valid=0, overrun=0, frame_err=0, bit_count=0, word_count=0, FSM=DISABLED, synchronizers=0.
- Clock-domain latency:
  - Let E be the clk edge at which sclk_in is first sampled high. rise is asserted in the cycle after edge E+SYNC_STAGES.
  - For the last bit, valid and data_out update on edge E+SYNC_STAGES+1.
- frame_err is high for exactly 1 cycle, IDLE_TIMEOUT cycles after the last rise of a partial frame.
- The transmitter's 2-cycle bit period gives a WIDTH-bit word every 2·WIDTH clk cycles. Back-to-back frames with no idle gap are received correctly.
- A rise arriving in the same cycle the timeout fires is counted as a bit, and no timeout occurs.

## Test plan
- Send 0xA5C3_0F81 from the serializer model, enable=1, ack tied high → valid pulses 1 cycle, data_out=0xA5C30F81, word_count=1, overrun=0.
- Two back-to-back words 0xFFFF_FFFF then 0x0000_0001, ack=0 until after the second → data_out=0xFFFFFFFF, valid=1, overrun=1, word_count=2. Then clr → overrun=0.
- 20 bits, then sclk_in held low for 16 cycles → frame_err pulses once. A following full word 0x1234_5678 is received intact.
- Word completes in the same cycle ack=1 with valid already 1 → valid stays 1, data_out takes the new word, overrun=0.
- Assert rst after 10 bits, release, send 0xDEAD_BEEF → all outputs at reset values after rst, then data_out=0xDEADBEEF, word_count=1.
- Drop enable after 8 bits, raise it, send 0x8000_0000 → no frame_err, data_out=0x80000000.

Source files
------------

// File: rtl/sipo_rx.sv
// Serial-in/parallel-out receiver: oversamples a forwarded serial clock, shifts data MSB first,
// and hands completed words downstream through a valid/ack handshake with overrun/abort flags.
module sipo_rx #(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned IDLE_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             sclk_in,
    input  logic             sdata_in,
    input  logic             ack,
    input  logic             clr,
    output logic [WIDTH-1:0] data_out,
    output logic             valid,
    output logic             overrun,
    output logic             frame_err,
    output logic [5:0]       bit_count,
    output logic [15:0]      word_count
);

    localparam logic [1:0] StDisabled = 2'd0;
    localparam logic [1:0] StWait     = 2'd1;
    localparam logic [1:0] StShift    = 2'd2;

    localparam int unsigned IdleW    = $clog2(IDLE_TIMEOUT);
    localparam logic [IdleW-1:0] IdleLast = IdleW'(IDLE_TIMEOUT - 1);
    localparam logic [5:0]       LastBit  = 6'(WIDTH - 1);

    logic [SYNC_STAGES-1:0] sclk_sync_q, sdata_sync_q;
    logic                   sclk_s, sdata_s;
    logic                   sclk_q, rise_q, sdata_q;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [5:0]       bit_cnt_q, bit_cnt_d;
    logic [IdleW-1:0] idle_q, idle_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             overrun_q, overrun_d;
    logic             frame_err_q, frame_err_d;
    logic [15:0]      word_cnt_q, word_cnt_d;
    logic             complete, overrun_set;
    logic [WIDTH-1:0] shifted;

    assign sclk_s  = sclk_sync_q[SYNC_STAGES-1];
    assign sdata_s = sdata_sync_q[SYNC_STAGES-1];
    assign shifted = {shift_q[WIDTH-2:0], sdata_q};

    // Edge detect is registered; sdata_q is captured alongside so the bit stays aligned with rise_q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync_q  <= '0;
            sdata_sync_q <= '0;
            sclk_q       <= 1'b0;
            rise_q       <= 1'b0;
            sdata_q      <= 1'b0;
        end else begin
            sclk_sync_q  <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_in};
            sdata_sync_q <= {sdata_sync_q[SYNC_STAGES-2:0], sdata_in};
            sclk_q       <= sclk_s;
            rise_q       <= sclk_s & ~sclk_q;
            sdata_q      <= sdata_s;
        end
    end

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        idle_d      = idle_q;
        frame_err_d = 1'b0;
        complete    = 1'b0;
        if (!enable) begin
            state_d   = StDisabled;
            bit_cnt_d = '0;
            idle_d    = '0;
        end else begin
            case (state_q)
                StDisabled: state_d = StWait;
                StWait: begin
                    if (rise_q) begin
                        shift_d   = shifted;
                        bit_cnt_d = 6'd1;
                        idle_d    = '0;
                        state_d   = StShift;
                    end
                end
                StShift: begin
                    if (rise_q) begin
                        shift_d = shifted;
                        idle_d  = '0;
                        if (bit_cnt_q == LastBit) begin
                            complete  = 1'b1;
                            bit_cnt_d = '0;
                            state_d   = StWait;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 6'd1;
                        end
                    end else if (idle_q == IdleLast) begin
                        frame_err_d = 1'b1;
                        shift_d     = '0;
                        bit_cnt_d   = '0;
                        idle_d      = '0;
                        state_d     = StWait;
                    end else begin
                        idle_d = idle_q + 1'b1;
                    end
                end
                default: state_d = StDisabled;
            endcase
        end
    end

    // A completion in the ack cycle replaces the word being consumed rather than overrunning.
    always_comb begin
        data_d      = data_q;
        valid_d     = valid_q;
        word_cnt_d  = word_cnt_q;
        overrun_set = 1'b0;
        if (complete) begin
            word_cnt_d = word_cnt_q + 16'd1;
            if (!valid_q || ack) begin
                data_d  = shifted;
                valid_d = 1'b1;
            end else begin
                overrun_set = 1'b1;
            end
        end else if (valid_q && ack) begin
            valid_d = 1'b0;
        end
        overrun_d = overrun_set ? 1'b1 : (clr ? 1'b0 : overrun_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StDisabled;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            idle_q      <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            word_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            idle_q      <= idle_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
            word_cnt_q  <= word_cnt_d;
        end
    end

    assign data_out   = data_q;
    assign valid      = valid_q;
    assign overrun    = overrun_q;
    assign frame_err  = frame_err_q;
    assign bit_count  = bit_cnt_q;
    assign word_count = word_cnt_q;

endmodule

// File: tb/tb_sipo_rx.sv
// Bench for sipo_rx: table of words with ack held high, hand-written corner sequences, and
// random batches checked against a queue-based model of what the consumer should observe.
module tb_sipo_rx;

    localparam int W = 32;
    localparam int S = 2;

    logic          clk = 1'b0;
    logic          rst, enable, sclk_in, sdata_in, ack, clr;
    logic [W-1:0]  data_out;
    logic          valid, overrun, frame_err;
    logic [5:0]    bit_count;
    logic [15:0]   word_count;

    sipo_rx #(.WIDTH(W), .SYNC_STAGES(S), .IDLE_TIMEOUT(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .sclk_in    (sclk_in),
        .sdata_in   (sdata_in),
        .ack        (ack),
        .clr        (clr),
        .data_out   (data_out),
        .valid      (valid),
        .overrun    (overrun),
        .frame_err  (frame_err),
        .bit_count  (bit_count),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int fe_cnt = 0;
    logic [15:0] exp_wc;

    always @(negedge clk) if (frame_err) fe_cnt++;

    typedef struct {
        logic [31:0] word;
        logic [31:0] exp_data;
        logic [15:0] exp_wc;
    } vec_t;
    vec_t tbl[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Serializer model: 2-cycle bit period, data changes with the falling serial clock.
    task automatic send_bits(input logic [31:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            sclk_in  = 1'b0;
            sdata_in = w[W-1-i];
            @(negedge clk);
            sclk_in = 1'b1;
        end
    endtask

    task automatic wait_valid(input string name, output int lat);
        bit found = 0;
        lat = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (valid) found = 1;
        end
        if (!found) begin
            checks++;
            failures++;
            $display("FAIL %s valid never rose actual=0 required=1", name);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_data"}, data_out, 0);
        check({tag, "_valid"}, valid, 0);
        check({tag, "_overrun"}, overrun, 0);
        check({tag, "_frame_err"}, frame_err, 0);
        check({tag, "_bit_count"}, bit_count, 0);
        check({tag, "_word_count"}, word_count, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish actual=running required=done");
        $fatal(1);
    end

    initial begin
        int lat;
        int fe0;
        int k;
        logic [31:0] w;
        logic [31:0] q[$];

        tbl[0] = '{32'hA5C3_0F81, 32'hA5C3_0F81, 16'd1};
        tbl[1] = '{32'h1234_5678, 32'h1234_5678, 16'd2};
        tbl[2] = '{32'hDEAD_BEEF, 32'hDEAD_BEEF, 16'd3};
        tbl[3] = '{32'h8000_0000, 32'h8000_0000, 16'd4};
        tbl[4] = '{32'h0000_0001, 32'h0000_0001, 16'd5};
        tbl[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 16'd6};

        rst = 1'b1; enable = 1'b0; sclk_in = 1'b0; sdata_in = 1'b0; ack = 1'b0; clr = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;
        enable = 1'b1;
        repeat (2) @(negedge clk);

        // Table: ack tied high, each word yields a one-cycle valid pulse.
        ack = 1'b1;
        for (int i = 0; i < 6; i++) begin
            send_bits(tbl[i].word, W);
            wait_valid("tbl_valid", lat);
            if (i == 0) check("latency_last_bit", lat, S + 2);
            check("tbl_data", data_out, tbl[i].exp_data);
            check("tbl_word_count", word_count, tbl[i].exp_wc);
            check("tbl_overrun", overrun, 0);
            @(posedge clk); #1;
            check("tbl_valid_pulse", valid, 0);
        end
        exp_wc = 16'd6;

        // Overrun: two back-to-back words with no ack.
        @(negedge clk); ack = 1'b0;
        send_bits(32'hFFFF_FFFF, W);
        send_bits(32'h0000_0001, W);
        repeat (6) @(posedge clk);
        #1;
        exp_wc += 2;
        check("ovr_data", data_out, 32'hFFFF_FFFF);
        check("ovr_valid", valid, 1);
        check("ovr_flag", overrun, 1);
        check("ovr_word_count", word_count, exp_wc);
        @(negedge clk); clr = 1'b1;
        @(negedge clk); clr = 1'b0;
        check("clr_overrun", overrun, 0);
        check("clr_keeps_valid", valid, 1);

        // Completion in the very cycle ack is high with valid already set.
        send_bits(32'hCAFE_F00D, W);
        repeat (3) @(posedge clk);
        @(negedge clk); ack = 1'b1;
        @(posedge clk); #1;
        exp_wc++;
        check("same_cycle_valid", valid, 1);
        check("same_cycle_data", data_out, 32'hCAFE_F00D);
        check("same_cycle_overrun", overrun, 0);
        @(negedge clk); ack = 1'b0;
        @(posedge clk); #1;
        check("same_cycle_valid_held", valid, 1);
        @(negedge clk); ack = 1'b1;
        @(negedge clk); ack = 1'b0;
        check("ack_drops_valid", valid, 0);

        // Truncated frame: 20 bits then the serial clock stops.
        fe0 = fe_cnt;
        send_bits(32'h0F0F_0F0F, 20);
        @(negedge clk); sclk_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("partial_bit_count", bit_count, 20);
        repeat (40) @(negedge clk);
        check("timeout_one_pulse", fe_cnt - fe0, 1);
        check("timeout_bit_count", bit_count, 0);
        ack = 1'b1;
        send_bits(32'h1234_5678, W);
        wait_valid("after_timeout_valid", lat);
        exp_wc++;
        check("after_timeout_data", data_out, 32'h1234_5678);
        check("after_timeout_word_count", word_count, exp_wc);

        // Asynchronous reset mid-frame.
        @(negedge clk); ack = 1'b0;
        send_bits(32'h3C3C_3C3C, 10);
        @(negedge clk);
        #2 rst = 1'b1; sclk_in = 1'b0;
        #1 check_reset_values("midframe_rst");
        @(negedge clk); rst = 1'b0;
        exp_wc = 0;
        repeat (3) @(negedge clk);
        ack = 1'b1;
        send_bits(32'hDEAD_BEEF, W);
        wait_valid("post_rst_valid", lat);
        exp_wc++;
        check("post_rst_data", data_out, 32'hDEAD_BEEF);
        check("post_rst_word_count", word_count, exp_wc);

        // Enable dropped mid-frame: silent discard.
        fe0 = fe_cnt;
        send_bits(32'hFFFF_FFFF, 8);
        @(negedge clk); enable = 1'b0;
        repeat (3) @(negedge clk);
        check("disable_bit_count", bit_count, 0);
        enable = 1'b1;
        @(negedge clk);
        send_bits(32'h8000_0000, W);
        wait_valid("reenable_valid", lat);
        exp_wc++;
        check("reenable_data", data_out, 32'h8000_0000);
        check("reenable_word_count", word_count, exp_wc);
        check("disable_no_frame_err", fe_cnt - fe0, 0);
        @(posedge clk); #1;

        // Random batches with no ack: consumer should see the first word, overrun iff k > 1.
        for (int it = 0; it < 12; it++) begin
            @(negedge clk);
            ack = 1'b0;
            sclk_in = 1'b0;
            repeat ($urandom_range(0, 5)) @(negedge clk);
            k = $urandom_range(1, 3);
            q.delete();
            for (int j = 0; j < k; j++) begin
                w = $urandom;
                q.push_back(w);
                send_bits(w, W);
            end
            repeat (6) @(posedge clk);
            #1;
            exp_wc += 16'(k);
            check("rnd_data", data_out, q[0]);
            check("rnd_valid", valid, 1);
            check("rnd_overrun", overrun, (k > 1) ? 1 : 0);
            check("rnd_word_count", word_count, exp_wc);
            @(negedge clk); ack = 1'b1; clr = 1'b1;
            @(negedge clk); ack = 1'b0; clr = 1'b0;
            check("rnd_valid_cleared", valid, 0);
            check("rnd_overrun_cleared", overrun, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
